// File: rtl/ucode_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucode_seq_pkg
// Description : Shared encodings, entry vectors and opcode dispatch table
//               for the midgetv microcode sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ucode_seq_pkg;

    localparam logic [1:0] C_SNEXT_SEQ      = 2'b00;
    localparam logic [1:0] C_SNEXT_DISPATCH = 2'b01;
    localparam logic [1:0] C_SNEXT_BRANCH   = 2'b10;
    localparam logic [1:0] C_SNEXT_TRAP     = 2'b11;

    localparam logic [7:0] C_BOOT_ADR = 8'h00;
    localparam logic [7:0] C_TRAP_ADR = 8'hF0;
    localparam logic [7:0] C_IRQ_ADR  = 8'hF8;

    // Each entry is {legal, adr[7:0]}, indexed by instr[6:2].
    function automatic logic [31:0][8:0] f_build_dispatch_table();
        logic [31:0][8:0] t;
        t = '0;
        t[5'b00000] = {1'b1, 8'h10};  // LOAD
        t[5'b00011] = {1'b1, 8'h14};  // MISC-MEM
        t[5'b00100] = {1'b1, 8'h20};  // OP-IMM
        t[5'b00101] = {1'b1, 8'h28};  // AUIPC
        t[5'b01000] = {1'b1, 8'h30};  // STORE
        t[5'b01100] = {1'b1, 8'h40};  // OP
        t[5'b01101] = {1'b1, 8'h48};  // LUI
        t[5'b11000] = {1'b1, 8'h50};  // BRANCH
        t[5'b11001] = {1'b1, 8'h60};  // JALR
        t[5'b11011] = {1'b1, 8'h68};  // JAL
        t[5'b11100] = {1'b1, 8'h70};  // SYSTEM
        return t;
    endfunction

    localparam logic [31:0][8:0] C_DISPATCH_TABLE = f_build_dispatch_table();

endpackage
`default_nettype wire

// File: rtl/m_ucode_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : m_ucode_dispatch
// Description : Combinational opcode to microcode entry lookup.
// Revision    : 1.0 - initial release
// ============================================================================
import ucode_seq_pkg::*;

module m_ucode_dispatch (
    input  logic [4:0] opcode,
    input  logic       opvalid,
    output logic       legal,
    output logic [7:0] adr
);

    logic [8:0] w_entry;

    assign w_entry = C_DISPATCH_TABLE[opcode];
    assign legal   = opvalid & w_entry[8];
    assign adr     = w_entry[7:0];

endmodule
`default_nettype wire

// File: rtl/m_ucode_seq.sv
`default_nettype none
// ============================================================================
// Module      : m_ucode_seq
// Description : Microcode sequencer; computes the next control-store address.
//               Interrupt accept is built only with UCODE_SEQ_IRQ_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
import ucode_seq_pkg::*;

module m_ucode_seq #(
    parameter logic [7:0]  BOOT_ADR   = C_BOOT_ADR,
    parameter logic [7:0]  TRAP_ADR   = C_TRAP_ADR,
    parameter logic [7:0]  IRQ_ADR    = C_IRQ_ADR,
    parameter int unsigned RESET_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rinx,
    input  logic [1:0] s_next,
    input  logic       brcond,
    input  logic [4:0] opcode,
    input  logic       opvalid,
    input  logic       progress_ucode,
    input  logic       irq_pending,
    input  logic       irq_enable,
    output logic [7:0] minx,
    output logic       in_boot,
    output logic       trap_taken,
    output logic       irq_taken
);

    localparam logic       S_BOOT      = 1'b0;
    localparam logic       S_RUN       = 1'b1;
    localparam logic [3:0] C_HOLD_INIT = 4'(RESET_HOLD);

    logic       r_state;
    logic [3:0] r_hold_cnt;
    logic [7:0] r_upc;

    logic       w_disp_legal;
    logic [7:0] w_disp_adr;
    logic [7:0] w_minx;
    logic       w_trap;
    logic       w_irq;

    m_ucode_dispatch u_dispatch (
        .opcode  (opcode),
        .opvalid (opvalid),
        .legal   (w_disp_legal),
        .adr     (w_disp_adr)
    );

    // Zero-latency address mux; a held cycle replays r_upc and never pulses.
    always_comb begin
        w_minx = r_upc;
        w_trap = 1'b0;
        w_irq  = 1'b0;
        if (r_state == S_BOOT) begin
            w_minx = BOOT_ADR;
        end else if (!progress_ucode) begin
            w_minx = r_upc;
        end
`ifdef UCODE_SEQ_IRQ_EN
        // Instruction boundary: a sequential word whose successor is the boot word.
        else if (irq_pending && irq_enable && (s_next == C_SNEXT_SEQ) && (rinx == BOOT_ADR)) begin
            w_minx = IRQ_ADR;
            w_irq  = 1'b1;
        end
`endif
        else begin
            case (s_next)
                C_SNEXT_SEQ: begin
                    w_minx = rinx;
                end
                C_SNEXT_BRANCH: begin
                    w_minx = {rinx[7:1], brcond};
                end
                C_SNEXT_DISPATCH: begin
                    if (w_disp_legal) begin
                        w_minx = w_disp_adr;
                    end else begin
                        w_minx = TRAP_ADR;
                        w_trap = 1'b1;
                    end
                end
                default: begin
                    w_minx = TRAP_ADR;
                    w_trap = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_hold_cnt <= C_HOLD_INIT;
            r_upc      <= BOOT_ADR;
        end else if (r_state == S_BOOT) begin
            r_upc <= BOOT_ADR;
            if (r_hold_cnt <= 4'd1) begin
                r_state    <= S_RUN;
                r_hold_cnt <= 4'd0;
            end else begin
                r_hold_cnt <= r_hold_cnt - 4'd1;
            end
        end else begin
            r_upc <= w_minx;
        end
    end

    assign minx       = w_minx;
    assign in_boot    = (r_state == S_BOOT);
    assign trap_taken = w_trap;

`ifdef UCODE_SEQ_IRQ_EN
    assign irq_taken = w_irq;
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{irq_pending, irq_enable, IRQ_ADR, w_irq};
    assign irq_taken    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_ucode_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_ucode_seq
// Description : Self-checking bench for m_ucode_seq with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_ucode_seq;

    logic       clk;
    logic       rst;
    logic [7:0] rinx;
    logic [1:0] s_next;
    logic       brcond;
    logic [4:0] opcode;
    logic       opvalid;
    logic       progress_ucode;
    logic       irq_pending;
    logic       irq_enable;
    logic [7:0] minx;
    logic       in_boot;
    logic       trap_taken;
    logic       irq_taken;

    int n_vec  = 0;
    int n_fail = 0;

    m_ucode_seq #(
        .BOOT_ADR   (8'h00),
        .TRAP_ADR   (8'hF0),
        .IRQ_ADR    (8'hF8),
        .RESET_HOLD (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rinx           (rinx),
        .s_next         (s_next),
        .brcond         (brcond),
        .opcode         (opcode),
        .opvalid        (opvalid),
        .progress_ucode (progress_ucode),
        .irq_pending    (irq_pending),
        .irq_enable     (irq_enable),
        .minx           (minx),
        .in_boot        (in_boot),
        .trap_taken     (trap_taken),
        .irq_taken      (irq_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef UCODE_SEQ_IRQ_EN
    localparam bit c_irq_on = 1'b1;
`else
    localparam bit c_irq_on = 1'b0;
`endif

    // RV32I entry points as documented for the control store; -1 = illegal.
    function automatic int rv_entry(input logic [4:0] op);
        case (op)
            5'b00000: return 'h10;
            5'b00011: return 'h14;
            5'b00100: return 'h20;
            5'b00101: return 'h28;
            5'b01000: return 'h30;
            5'b01100: return 'h40;
            5'b01101: return 'h48;
            5'b11000: return 'h50;
            5'b11001: return 'h60;
            5'b11011: return 'h68;
            5'b11100: return 'h70;
            default:  return -1;
        endcase
    endfunction

    // Model state: remaining boot cycles and last issued address.
    bit       m_valid = 1'b0;
    int       m_boot_left = 0;
    int       m_last = 0;

    function automatic void model_expect(output int em, output bit et, output bit ei, output bit eb);
        int e;
        em = 0; et = 1'b0; ei = 1'b0; eb = 1'b0;
        if (m_boot_left > 0) begin
            eb = 1'b1;
            em = 0;
        end else if (!progress_ucode) begin
            em = m_last;
        end else if (c_irq_on && irq_pending && irq_enable && s_next == 2'd0 && rinx == 8'h00) begin
            em = 'hF8;
            ei = 1'b1;
        end else if (s_next == 2'd0) begin
            em = int'(rinx);
        end else if (s_next == 2'd2) begin
            em = (int'(rinx) / 2) * 2 + int'(brcond);
        end else if (s_next == 2'd1) begin
            e = rv_entry(opcode);
            if (opvalid && e >= 0) em = e;
            else begin em = 'hF0; et = 1'b1; end
        end else begin
            em = 'hF0;
            et = 1'b1;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int em; bit et, ei, eb;
        if (rst) begin
            m_valid     = 1'b1;
            m_boot_left = 2;
            m_last      = 0;
        end else if (m_valid) begin
            if (m_boot_left > 0) begin
                m_boot_left = m_boot_left - 1;
            end else begin
                model_expect(em, et, ei, eb);
                m_last = em;
            end
        end
    end

    always @(negedge clk) begin
        int em; bit et, ei, eb;
        if (m_valid) begin
            model_expect(em, et, ei, eb);
            check("model_minx", int'(minx), em);
            check("model_in_boot", int'(in_boot), int'(eb));
            check("model_trap", int'(trap_taken), int'(et));
            check("model_irq", int'(irq_taken), int'(ei));
        end
    end

    task automatic apply(input logic [1:0] sn, input logic [7:0] ri, input logic bc,
                         input logic [4:0] op, input logic ov, input logic pg,
                         input logic ip, input logic ie);
        @(posedge clk);
        #1;
        s_next = sn; rinx = ri; brcond = bc; opcode = op; opvalid = ov;
        progress_ucode = pg; irq_pending = ip; irq_enable = ie;
    endtask

    // Hand-computed expectations, sampled mid-cycle after inputs settle.
    task automatic lit(input string name, input int em, input bit et, input bit ei, input bit eb);
        #3;
        check({name, "_minx"}, int'(minx), em);
        check({name, "_trap"}, int'(trap_taken), int'(et));
        check({name, "_irq"}, int'(irq_taken), int'(ei));
        check({name, "_boot"}, int'(in_boot), int'(eb));
    endtask

    initial begin
        rst = 1'b1; rinx = 8'h00; s_next = 2'd0; brcond = 1'b0; opcode = 5'd0;
        opvalid = 1'b0; progress_ucode = 1'b1; irq_pending = 1'b0; irq_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        lit("boot_a", 'h00, 0, 0, 1);
        apply(2'd0, 8'h00, 0, 5'd0, 0, 1, 0, 0);
        lit("boot_b", 'h00, 0, 0, 1);
        apply(2'd0, 8'h00, 0, 5'd0, 0, 1, 0, 0);
        lit("run_c", 'h00, 0, 0, 0);

        apply(2'd2, 8'h37, 1, 5'd0, 0, 1, 0, 0);  lit("br_taken", 'h37, 0, 0, 0);
        apply(2'd2, 8'h37, 0, 5'd0, 0, 1, 0, 0);  lit("br_not", 'h36, 0, 0, 0);
        apply(2'd0, 8'h41, 0, 5'd0, 0, 1, 0, 0);  lit("seq", 'h41, 0, 0, 0);
        apply(2'd1, 8'h00, 0, 5'b01100, 1, 1, 0, 0); lit("disp_op", 'h40, 0, 0, 0);
        apply(2'd1, 8'h00, 0, 5'b00010, 1, 1, 0, 0); lit("disp_ill", 'hF0, 1, 0, 0);
        apply(2'd0, 8'h41, 0, 5'b00010, 1, 1, 0, 0); lit("trap_once", 'h41, 0, 0, 0);
        apply(2'd1, 8'h00, 0, 5'b01100, 0, 1, 0, 0); lit("disp_novalid", 'hF0, 1, 0, 0);
        apply(2'd3, 8'h12, 0, 5'd0, 0, 1, 0, 0);  lit("trap_req", 'hF0, 1, 0, 0);

        for (int i = 0; i < 32; i++) apply(2'd1, 8'h00, 0, i[4:0], 1, 1, 0, 0);

        apply(2'd0, 8'h52, 0, 5'd0, 0, 1, 0, 0);  lit("pre_hold", 'h52, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(2'(i), 8'(8'h10 + i), 1, 5'b00010, 1, 0, 0, 0);
            lit("hold", 'h52, 0, 0, 0);
        end
        apply(2'd0, 8'h77, 0, 5'd0, 0, 1, 0, 0);  lit("resume", 'h77, 0, 0, 0);

        apply(2'd0, 8'h00, 0, 5'd0, 0, 1, 1, 1);
        lit("irq_acc", c_irq_on ? 'hF8 : 'h00, 0, c_irq_on, 0);
        apply(2'd0, 8'h05, 0, 5'd0, 0, 1, 1, 1);  lit("irq_midinstr", 'h05, 0, 0, 0);
        apply(2'd0, 8'h00, 0, 5'd0, 0, 0, 1, 1);  lit("irq_held", 'h05, 0, 0, 0);
        apply(2'd0, 8'h00, 0, 5'd0, 0, 1, 1, 1);
        lit("irq_deferred", c_irq_on ? 'hF8 : 'h00, 0, c_irq_on, 0);
        apply(2'd0, 8'h00, 0, 5'd0, 0, 1, 1, 0);  lit("irq_masked", 'h00, 0, 0, 0);

        apply(2'd2, 8'h33, 1, 5'd0, 0, 1, 0, 0);  lit("pre_rst", 'h33, 0, 0, 0);
        apply(2'd2, 8'h44, 1, 5'd0, 0, 0, 0, 0);
        rst = 1'b1;
        apply(2'd2, 8'h44, 1, 5'd0, 0, 0, 0, 0);
        rst = 1'b0;
        lit("rst_midrun", 'h00, 0, 0, 1);
        repeat (3) apply(2'd0, 8'h21, 0, 5'd0, 0, 1, 0, 0);
        lit("after_reboot", 'h21, 0, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_ucode_seq.md
Name: m_ucode_seq

Overview:
- Microcode sequencer for the midgetv control store. Each cycle it computes the next microcode address `minx` for the microcode ROM wrapper.
- Address sources: the ROM's own next-address field `rinx`, an opcode dispatch table, a conditional-branch rule, and fixed trap/interrupt entry vectors.
- Sits between instruction latch, ALU branch condition, bus handshake and the ucode ROM. Owns the only microprogram counter in the core.

Parameters:
- BOOT_ADR, 8'h00, address issued during and after reset.
- TRAP_ADR, 8'hF0, entry for illegal opcode or explicit trap request.
- IRQ_ADR, 8'hF8, interrupt entry (only with UCODE_SEQ_IRQ_EN).
- RESET_HOLD, 2, cycles BOOT_ADR is held after rst deasserts (1..15).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- rinx  in  8  next-address field from current microword
- s_next  in  2  sequencing mode from microword: 00 SEQ, 01 DISPATCH, 10 BRANCH, 11 TRAP
- brcond  in  1  ALU branch condition, valid in current cycle
- opcode  in  5  instr[6:2] of latched instruction
- opvalid  in  1  instr[1:0]==2'b11
- progress_ucode  in  1  0 = hold (shift/bus wait), repeat current address
- irq_pending  in  1  level interrupt request
- irq_enable  in  1  global interrupt enable (mstatus.MIE)
- minx  out  8  address presented to ucode ROM this cycle
- in_boot  out  1  high while boot hold is active
- trap_taken  out  1  one-cycle pulse when TRAP_ADR is issued
- irq_taken  out  1  one-cycle pulse when IRQ_ADR is issued

Behaviour:
- State upc_q[7:0] holds the last issued minx. FSM states: BOOT, RUN.
- On rst=1 at a clock edge: state goes to BOOT, hold counter = RESET_HOLD, upc_q = BOOT_ADR. All pulses are 0.
- Reset values of outputs: minx=BOOT_ADR, in_boot=1, trap_taken=0, irq_taken=0.
- BOOT state:
  - minx=BOOT_ADR; the counter decrements each cycle regardless of progress_ucode.
  - At 0, go to RUN. minx stays BOOT_ADR in that transition cycle, so the ROM fetches the boot word.
- RUN state: minx is combinational, same cycle, zero latency. Priority order:
  1. progress_ucode=0: minx=upc_q. No pulses. An irq in this cycle is deferred, not lost.
  2. irq accept (feature only): irq_pending & irq_enable & s_next==SEQ & rinx==BOOT_ADR. The instruction boundary is the microword whose next field is BOOT_ADR. Then minx=IRQ_ADR and irq_taken=1.
  3. s_next=SEQ: minx=rinx.
  4. s_next=BRANCH: minx={rinx[7:1], brcond}. rinx[0] is ignored.
  5. s_next=DISPATCH: if opvalid and the table entry is legal, minx=table[opcode]. Otherwise minx=TRAP_ADR and trap_taken=1.
  6. s_next=TRAP: minx=TRAP_ADR, trap_taken=1.
- upc_q <= minx every cycle in RUN.
- Pulses are asserted only in cycles with progress_ucode=1, so a held cycle never re-pulses.
- Address arithmetic is 8-bit with no increment, so wrap-around is impossible by construction.
- rst during a hold or mid-branch: rst wins unconditionally. Next cycle is BOOT.

Optional Feature:
- Macro UCODE_SEQ_IRQ_EN.
- Defined: interrupt accept as in priority 2; irq_taken is live.
- Undefined: irq_pending and irq_enable are ignored, irq_taken is tied 0, and IRQ_ADR is unused. Priority 2 does not exist.

Decomposition:
- Package ucode_seq_pkg holds:
  - the s_next encodings (SEQ/DISPATCH/BRANCH/TRAP);
  - the default BOOT/TRAP/IRQ vectors;
  - the 32-entry dispatch table constant {legal, adr[7:0]} indexed by opcode.
- Table content for RV32I opcodes: LOAD, MISC-MEM, OP-IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM legal; all others illegal.
- Sub-module m_ucode_dispatch: combinational lookup of opcode/opvalid to {legal, adr}. The top contains the FSM, counter, upc_q and mux.

Test Plan:
- Reset: hold rst 3 cycles, release with RESET_HOLD=2 -> minx=8'h00 and in_boot=1 for exactly 2 cycles, then RUN with in_boot=0.
- SEQ/BRANCH: s_next=10, rinx=8'h37, brcond=1 -> minx=8'h37; with brcond=0 -> minx=8'h36. s_next=00, rinx=8'h41 -> minx=8'h41.
- Dispatch: opcode=5'b01100 (OP), opvalid=1 -> minx equals the package entry. opcode=5'b00010 -> minx=8'hF0 and trap_taken high for 1 cycle. opvalid=0 -> minx=8'hF0.
- Hold: set progress_ucode=0 for 5 cycles after minx=8'h52 -> minx stays 8'h52 with s_next/rinx changing and no pulses. Resume -> follows the mux.
- IRQ (feature on): irq_pending=1, irq_enable=1, boundary word (SEQ, rinx=00) -> minx=8'hF8 and irq_taken=1 for 1 cycle. Same with progress_ucode=0 -> deferred to the first progress cycle. Feature off -> minx=8'h00.
- Reset mid-run: assert rst while in RUN with progress_ucode=0 -> next cycle minx=8'h00 and in_boot=1.
